// File: rtl/vga_pattern_sequencer_pkg.sv
// Shared constants for the VGA pattern sequencer: command bytes, widths,
// sequencer state encoding and index wrap helpers.
package vga_pattern_sequencer_pkg;

  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BYTE_W = 8;

  // ASCII command bytes
  localparam logic [BYTE_W-1:0] CMD_0     = 8'h30;
  localparam logic [BYTE_W-1:0] CMD_9     = 8'h39;
  localparam logic [BYTE_W-1:0] CMD_A_UP  = 8'h41;
  localparam logic [BYTE_W-1:0] CMD_A_LO  = 8'h61;
  localparam logic [BYTE_W-1:0] CMD_M_UP  = 8'h4D;
  localparam logic [BYTE_W-1:0] CMD_M_LO  = 8'h6D;
  localparam logic [BYTE_W-1:0] CMD_PLUS  = 8'h2B;
  localparam logic [BYTE_W-1:0] CMD_MINUS = 8'h2D;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } seq_state_e;

  // Increment an index, wrapping last -> 0
  function automatic logic [PAT_W-1:0] wrap_inc(input logic [PAT_W-1:0] v,
                                                input logic [PAT_W-1:0] last);
    return (v == last) ? '0 : v + PAT_W'(1);
  endfunction

  // Decrement an index, wrapping 0 -> last
  function automatic logic [PAT_W-1:0] wrap_dec(input logic [PAT_W-1:0] v,
                                                input logic [PAT_W-1:0] last);
    return (v == '0) ? last : v - PAT_W'(1);
  endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Frame tick detector: pulses on the rising edge of i_VSync (start of active video).
// Ports: i_Clk, i_Rst_L (async active-low), i_VSync in; o_Tick out (combinational,
// high in the cycle where i_VSync is high and was low on the previous edge).
module vga_frame_tick (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_VSync,
  output logic o_Tick
);

  logic vsync_prev_d;
  logic vsync_prev_q;

  always_comb begin
    vsync_prev_d = i_VSync;
  end

  // Reset to 1 so a high VSync at reset release is not seen as an edge
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vsync_prev_q <= 1'b1;
    end else begin
      vsync_prev_q <= vsync_prev_d;
    end
  end

  assign o_Tick = i_VSync & ~vsync_prev_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// VGA test-pattern sequencer: decodes ASCII commands into a pending pattern index
// and applies it only at frame ticks; AUTO mode steps the pattern every
// FRAMES_PER_STEP frames.
// Ports: i_Clk, i_Rst_L (async active-low); i_RX_DV/i_RX_Byte command input;
// i_VSync from sync generator; o_Pattern index, o_Pattern_Strobe change pulse,
// o_Auto mode flag, o_Cmd_Err bad-command pulse.
module vga_pattern_sequencer
  import vga_pattern_sequencer_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS    = 8,
  parameter int unsigned FRAMES_PER_STEP = 60
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_RX_DV,
  input  logic [BYTE_W-1:0] i_RX_Byte,
  input  logic              i_VSync,
  output logic [PAT_W-1:0]  o_Pattern,
  output logic              o_Pattern_Strobe,
  output logic              o_Auto,
  output logic              o_Cmd_Err
);

  localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAMES_PER_STEP - 1);

  logic tick;

  vga_frame_tick u_frame_tick (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_VSync (i_VSync),
    .o_Tick  (tick)
  );

  seq_state_e       state_d,    state_q;
  logic [PAT_W-1:0] pattern_d,  pattern_q;
  logic [PAT_W-1:0] pending_d,  pending_q;
  logic             pend_vld_d, pend_vld_q;
  logic [CNT_W-1:0] cnt_d,      cnt_q;
  logic             strobe_d,   strobe_q;
  logic             cmd_err_d,  cmd_err_q;

  logic [BYTE_W-1:0] digit_off;
  logic              is_digit;
  logic              is_auto;
  logic              is_manual;
  logic [PAT_W-1:0]  step_base;

  // Command classification
  always_comb begin
    digit_off = i_RX_Byte - CMD_0;
    is_digit  = (i_RX_Byte >= CMD_0) && (i_RX_Byte <= CMD_9) &&
                (digit_off < BYTE_W'(NUM_PATTERNS));
    is_auto   = (i_RX_Byte == CMD_A_UP) || (i_RX_Byte == CMD_A_LO);
    is_manual = (i_RX_Byte == CMD_M_UP) || (i_RX_Byte == CMD_M_LO);
    step_base = pend_vld_q ? pending_q : pattern_q;
  end

  // Next state: tick acts on pre-edge pending/state, then the command overlays
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    cmd_err_d  = 1'b0;
    strobe_d   = 1'b0;

    if (tick) begin
      if (pend_vld_q) begin
        pattern_d  = pending_q;
        pend_vld_d = 1'b0;
        if (state_q == ST_AUTO) begin
          cnt_d = '0;
        end
      end else if (state_q == ST_AUTO) begin
        if (cnt_q == LAST_CNT) begin
          pattern_d = wrap_inc(pattern_q, LAST_PAT);
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    if (i_RX_DV) begin
      if (is_digit) begin
        pending_d  = PAT_W'(digit_off);
        pend_vld_d = 1'b1;
        state_d    = ST_MANUAL;
      end else if (is_auto) begin
        state_d = ST_AUTO;
        cnt_d   = '0;
      end else if (is_manual) begin
        state_d = ST_MANUAL;
      end else if (i_RX_Byte == CMD_PLUS) begin
        pending_d  = wrap_inc(step_base, LAST_PAT);
        pend_vld_d = 1'b1;
      end else if (i_RX_Byte == CMD_MINUS) begin
        pending_d  = wrap_dec(step_base, LAST_PAT);
        pend_vld_d = 1'b1;
      end else begin
        cmd_err_d = 1'b1;
      end
    end

    strobe_d = (pattern_d != pattern_q);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= ST_MANUAL;
      pattern_q  <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      strobe_q   <= strobe_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign o_Pattern        = pattern_q;
  assign o_Pattern_Strobe = strobe_q;
  assign o_Auto           = (state_q == ST_AUTO);
  assign o_Cmd_Err        = cmd_err_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer (8 patterns, 2 frames per step):
// directed scenarios with literal expectations, then randomized commands and
// VSync timing, all checked every cycle against a behavioural model.
module tb_vga_pattern_sequencer;

  localparam int N   = 8;
  localparam int FPS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       vsync;
  logic [3:0] pat;
  logic       strobe;
  logic       auto_o;
  logic       err;

  vga_pattern_sequencer #(
    .NUM_PATTERNS    (N),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .i_Clk            (clk),
    .i_Rst_L          (rst_n),
    .i_RX_DV          (rx_dv),
    .i_RX_Byte        (rx_byte),
    .i_VSync          (vsync),
    .o_Pattern        (pat),
    .o_Pattern_Strobe (strobe),
    .o_Auto           (auto_o),
    .o_Cmd_Err        (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: what the DUT outputs must be after the most recent clock edge
  int m_pat;
  int m_pend;   // -1 means no pending index
  int m_cnt;
  bit m_auto;
  bit m_strobe;
  bit m_err;
  bit m_prev_vs;
  bit cur_vs;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    chk("pattern", 32'(pat), m_pat);
    chk("strobe", 32'(strobe), int'(m_strobe));
    chk("auto", 32'(auto_o), int'(m_auto));
    chk("cmd_err", 32'(err), int'(m_err));
  endtask

  function automatic void model_reset();
    m_pat = 0; m_pend = -1; m_cnt = 0;
    m_auto = 0; m_strobe = 0; m_err = 0; m_prev_vs = 1;
  endfunction

  // Advance the model by one clock edge given the inputs present at that edge
  function automatic void model_step(bit dv, logic [7:0] b, bit vs);
    bit tick;
    int new_pat, new_pend, new_cnt, base, d;
    bit new_auto, new_err;
    tick = vs && !m_prev_vs;
    m_prev_vs = vs;
    new_pat = m_pat; new_pend = m_pend; new_cnt = m_cnt;
    new_auto = m_auto; new_err = 0;
    if (tick) begin
      if (m_pend >= 0) begin
        new_pat = m_pend;
        new_pend = -1;
        if (m_auto) new_cnt = 0;
      end else if (m_auto) begin
        if (m_cnt == FPS - 1) begin
          new_pat = (m_pat + 1) % N;
          new_cnt = 0;
        end else begin
          new_cnt = m_cnt + 1;
        end
      end
    end
    if (dv) begin
      d = int'(b) - 48;
      base = (m_pend >= 0) ? m_pend : m_pat;
      if (d >= 0 && d <= 9 && d < N) begin
        new_pend = d; new_auto = 0;
      end else if (b == "A" || b == "a") begin
        new_auto = 1; new_cnt = 0;
      end else if (b == "M" || b == "m") begin
        new_auto = 0;
      end else if (b == "+") begin
        new_pend = (base + 1) % N;
      end else if (b == "-") begin
        new_pend = (base + N - 1) % N;
      end else begin
        new_err = 1;
      end
    end
    m_strobe = (new_pat != m_pat);
    m_pat = new_pat; m_pend = new_pend; m_cnt = new_cnt;
    m_auto = new_auto; m_err = new_err;
  endfunction

  // One clock: check current outputs, drive inputs, let the edge happen
  task automatic cycle(input bit dv, input logic [7:0] b, input bit vs);
    compare_outputs();
    rx_dv = dv; rx_byte = b; vsync = vs; cur_vs = vs;
    model_step(dv, b, vs);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, cur_vs);
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, cur_vs);
  endtask

  // Low for two cycles then rise; returns just after the tick edge
  task automatic frame();
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic frame_send(input logic [7:0] b);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, b, 1'b1);
  endtask

  task automatic do_reset(input int n);
    rx_dv = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_outputs();
    end
    rst_n = 1'b1;
  endtask

  logic [7:0] pool [13];

  initial begin
    int run;
    bit vs_r;
    int k;
    logic [7:0] b;

    pool = '{8'h30, 8'h33, 8'h37, 8'h38, 8'h39, 8'h41, 8'h61,
             8'h4D, 8'h6D, 8'h2B, 8'h2D, 8'h78, 8'h2B};
    rx_dv = 1'b0; rx_byte = 8'h00; vsync = 1'b1; cur_vs = 1'b1;
    do_reset(3);

    // Release with VSync high: no tick, pattern stays 0 for three frames
    idle(2);
    for (int f = 0; f < 3; f++) begin
      frame();
      chk("rel_pat", 32'(pat), 0);
      chk("rel_auto", 32'(auto_o), 0);
      chk("rel_strobe", 32'(strobe), 0);
      idle(2);
    end

    // Mid-frame digit waits for the next frame start
    send("3");
    idle(2);
    chk("mid_frame_hold", 32'(pat), 0);
    frame();
    chk("digit3_pat", 32'(pat), 3);
    chk("digit3_strobe", 32'(strobe), 1);
    idle(1);
    send("7");
    frame();
    chk("digit7_pat", 32'(pat), 7);

    // Out-of-range digit and unknown byte
    send("9");
    chk("err9_pulse", 32'(err), 1);
    chk("err9_pat", 32'(pat), 7);
    idle(1);
    send("x");
    chk("errx_pulse", 32'(err), 1);
    frame();
    chk("err_no_change", 32'(pat), 7);
    chk("err_no_strobe", 32'(strobe), 0);

    // Step wrapping and last-wins within a frame
    send("0"); frame(); chk("set0", 32'(pat), 0);
    send("-"); frame(); chk("minus_wrap", 32'(pat), 7);
    send("+"); frame(); chk("plus_wrap", 32'(pat), 0);
    send("2"); frame(); chk("set2", 32'(pat), 2);
    send("+"); send("+"); send("+");
    frame(); chk("plus3", 32'(pat), 5);

    // Command in the same cycle as a tick
    send("2");
    idle(1);
    frame_send("4");
    chk("coinc_old", 32'(pat), 2);
    frame();
    chk("coinc_new", 32'(pat), 4);

    // Auto stepping every second frame from 6
    send("6"); frame(); chk("auto_start", 32'(pat), 6);
    send("A");
    chk("auto_on", 32'(auto_o), 1);
    frame(); chk("auto_t1", 32'(pat), 6);
    frame(); chk("auto_t2", 32'(pat), 7);
    frame(); frame(); chk("auto_t4", 32'(pat), 0);
    frame(); frame(); chk("auto_t6", 32'(pat), 1);
    send("m");
    chk("manual_on", 32'(auto_o), 0);
    frame(); frame(); frame();
    chk("frozen", 32'(pat), 1);

    // Reset mid auto-step discards pending and count
    send("A"); frame(); send("+");
    do_reset(2);
    idle(1);
    frame();
    chk("post_rst_pat", 32'(pat), 0);
    chk("post_rst_auto", 32'(auto_o), 0);
    frame();
    chk("post_rst_pat2", 32'(pat), 0);

    // Randomized commands and frame timing
    run = 0;
    vs_r = cur_vs;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        vs_r = !vs_r;
        run = $urandom_range(1, 6);
      end
      run--;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 13);
        b = (k == 13) ? 8'($urandom) : pool[k];
        cycle(1'b1, b, vs_r);
      end else begin
        cycle(1'b0, 8'h00, vs_r);
      end
    end
    compare_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
